// File: rtl/game_result_latch.sv
// Round/match result latch for N-player tic-tac-toe: first winner locks out later claims,
// draws are counted, match ends at WIN_TARGET. Optional macro GAME_RESULT_TIE_DRAW_EN scores simultaneous claims as a draw.
module game_result_latch #(
    parameter int N_PLAYERS  = 2,
    parameter int SCORE_W    = 4,
    parameter int WIN_TARGET = 3,
    localparam int ID_W      = (N_PLAYERS > 2) ? $clog2(N_PLAYERS) : 1
) (
    input  logic                           i_clk,
    input  logic                           i_reset,
    input  logic [N_PLAYERS-1:0]           i_player_win,
    input  logic                           i_board_full,
    input  logic                           i_new_game,
    input  logic                           i_clear_match,
    output logic [N_PLAYERS-1:0]           o_winner,
    output logic [ID_W-1:0]                o_winner_id,
    output logic                           o_draw,
    output logic                           o_game_over,
    output logic                           o_match_over,
    output logic [N_PLAYERS*SCORE_W-1:0]   o_scores,
    output logic [SCORE_W-1:0]             o_draw_count
);

    typedef enum logic [1:0] {ST_PLAY, ST_WIN, ST_DRAW, ST_MATCH_OVER} state_t;

    localparam logic [SCORE_W-1:0] TARGET = SCORE_W'(WIN_TARGET);

    state_t               r_state, w_state_next;
    logic [N_PLAYERS-1:0] r_winner, w_winner_next;
    logic [ID_W-1:0]      r_winner_id, w_winner_id_next;
    logic                 r_draw, w_draw_next;
    logic                 r_game_over, r_match_over;
    logic [SCORE_W-1:0]   r_scores [N_PLAYERS];
    logic [SCORE_W-1:0]   w_scores_next [N_PLAYERS];
    logic [SCORE_W-1:0]   r_draw_count, w_draw_count_next;

    logic [N_PLAYERS-1:0] w_win_onehot;
    logic [ID_W-1:0]      w_win_idx;
    logic [SCORE_W-1:0]   w_win_score;
    logic                 w_any_win;
    logic                 w_tie;

    function automatic logic [SCORE_W-1:0] f_sat_inc(input logic [SCORE_W-1:0] v);
        return (v == {SCORE_W{1'b1}}) ? v : v + SCORE_W'(1);
    endfunction

    assign w_any_win    = |i_player_win;
    // Two's-complement trick isolates the lowest set claim.
    assign w_win_onehot = i_player_win & (~i_player_win + N_PLAYERS'(1));

`ifdef GAME_RESULT_TIE_DRAW_EN
    assign w_tie = |(i_player_win & (i_player_win - N_PLAYERS'(1)));
`else
    assign w_tie = 1'b0;
`endif

    always_comb begin
        w_win_idx = '0;
        for (int i = N_PLAYERS - 1; i >= 0; i--) begin
            if (i_player_win[i]) w_win_idx = ID_W'(i);
        end
    end

    assign w_win_score = f_sat_inc(r_scores[w_win_idx]);

    always_comb begin
        w_state_next      = r_state;
        w_winner_next     = r_winner;
        w_winner_id_next  = r_winner_id;
        w_draw_next       = r_draw;
        w_scores_next     = r_scores;
        w_draw_count_next = r_draw_count;
        if (i_clear_match) begin
            w_state_next      = ST_PLAY;
            w_winner_next     = '0;
            w_winner_id_next  = '0;
            w_draw_next       = 1'b0;
            w_draw_count_next = '0;
            for (int i = 0; i < N_PLAYERS; i++) w_scores_next[i] = '0;
        end else begin
            case (r_state)
                ST_PLAY: begin
                    // A real win outranks board_full; new_game is meaningless mid-round.
                    if (w_any_win && !w_tie) begin
                        w_winner_next            = w_win_onehot;
                        w_winner_id_next         = w_win_idx;
                        w_scores_next[w_win_idx] = w_win_score;
                        w_state_next = (w_win_score == TARGET) ? ST_MATCH_OVER : ST_WIN;
                    end else if (w_tie || i_board_full) begin
                        w_draw_next       = 1'b1;
                        w_draw_count_next = f_sat_inc(r_draw_count);
                        w_state_next      = ST_DRAW;
                    end
                end
                ST_WIN, ST_DRAW: begin
                    if (i_new_game) begin
                        w_state_next     = ST_PLAY;
                        w_winner_next    = '0;
                        w_winner_id_next = '0;
                        w_draw_next      = 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            r_state      <= ST_PLAY;
            r_winner     <= '0;
            r_winner_id  <= '0;
            r_draw       <= 1'b0;
            r_game_over  <= 1'b0;
            r_match_over <= 1'b0;
            r_draw_count <= '0;
            for (int i = 0; i < N_PLAYERS; i++) r_scores[i] <= '0;
        end else begin
            r_state      <= w_state_next;
            r_winner     <= w_winner_next;
            r_winner_id  <= w_winner_id_next;
            r_draw       <= w_draw_next;
            r_game_over  <= (w_state_next != ST_PLAY);
            r_match_over <= (w_state_next == ST_MATCH_OVER);
            r_draw_count <= w_draw_count_next;
            r_scores     <= w_scores_next;
        end
    end

    assign o_winner     = r_winner;
    assign o_winner_id  = r_winner_id;
    assign o_draw       = r_draw;
    assign o_game_over  = r_game_over;
    assign o_match_over = r_match_over;
    assign o_draw_count = r_draw_count;

    generate
        for (genvar gi = 0; gi < N_PLAYERS; gi++) begin : g_score_pack
            assign o_scores[gi*SCORE_W +: SCORE_W] = r_scores[gi];
        end
    endgenerate

endmodule

// File: tb/tb_game_result_latch.sv
// Bench for game_result_latch: directed scenarios with fixed expectations, then random
// stimulus checked against a round/match reference model.
module tb_game_result_latch;
    localparam int N    = 2;
    localparam int SW   = 4;
    localparam int TGT  = 3;
    localparam int IDW  = 1;
    localparam int SMAX = (1 << SW) - 1;
    localparam int VW   = N + IDW + 3 + N*SW + SW;
`ifdef GAME_RESULT_TIE_DRAW_EN
    localparam bit TIE_EN = 1'b1;
`else
    localparam bit TIE_EN = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [N-1:0]    pw_in = '0;
    logic            bf_in = 1'b0, ng_in = 1'b0, cm_in = 1'b0;
    logic [N-1:0]    o_winner;
    logic [IDW-1:0]  o_winner_id;
    logic            o_draw, o_game_over, o_match_over;
    logic [N*SW-1:0] o_scores;
    logic [SW-1:0]   o_draw_count;
    logic [VW-1:0]   dut_vec;

    int n_cmp  = 0;
    int n_fail = 0;

    // Reference model: round phase flags plus integer tallies.
    int m_score [N];
    int m_draws;
    int m_winner;
    bit m_draw, m_over, m_match;

    always #5 clk = ~clk;

    game_result_latch #(.N_PLAYERS(N), .SCORE_W(SW), .WIN_TARGET(TGT)) dut (
        .i_clk(clk), .i_reset(rst_n), .i_player_win(pw_in), .i_board_full(bf_in),
        .i_new_game(ng_in), .i_clear_match(cm_in), .o_winner(o_winner),
        .o_winner_id(o_winner_id), .o_draw(o_draw), .o_game_over(o_game_over),
        .o_match_over(o_match_over), .o_scores(o_scores), .o_draw_count(o_draw_count)
    );

    assign dut_vec = {o_winner, o_winner_id, o_draw, o_game_over, o_match_over, o_scores, o_draw_count};

    task automatic model_clear();
        for (int i = 0; i < N; i++) m_score[i] = 0;
        m_draws = 0; m_winner = -1; m_draw = 0; m_over = 0; m_match = 0;
    endtask

    task automatic model_step(input logic [N-1:0] pw, input logic bf, input logic ng,
                              input logic cm, input logic rst);
        int k, nb;
        if (!rst || cm) begin
            model_clear();
        end else if (m_match) begin
            // match decided: only clear/reset matter
        end else if (m_over) begin
            if (ng) begin m_over = 0; m_winner = -1; m_draw = 0; end
        end else begin
            nb = $countones(pw);
            k = -1;
            for (int i = N - 1; i >= 0; i--) if (pw[i]) k = i;
            if (nb > 0 && !(TIE_EN && nb >= 2)) begin
                m_winner = k;
                m_score[k] = (m_score[k] < SMAX) ? m_score[k] + 1 : SMAX;
                m_over = 1;
                m_match = (m_score[k] == TGT);
            end else if (nb > 0 || bf) begin
                m_draw = 1; m_over = 1;
                m_draws = (m_draws < SMAX) ? m_draws + 1 : SMAX;
            end
        end
    endtask

    function automatic logic [VW-1:0] model_vec();
        logic [N-1:0]    w = '0;
        logic [N*SW-1:0] s;
        if (m_winner >= 0) w[m_winner] = 1'b1;
        for (int i = 0; i < N; i++) s[i*SW +: SW] = SW'(m_score[i]);
        return {w, IDW'((m_winner >= 0) ? m_winner : 0), m_draw, m_over, m_match, s, SW'(m_draws)};
    endfunction

    task automatic cycle(input logic [N-1:0] pw, input logic bf, input logic ng,
                         input logic cm, input logic rst);
        pw_in = pw; bf_in = bf; ng_in = ng; cm_in = cm; rst_n = rst;
        model_step(pw, bf, ng, cm, rst);
        @(posedge clk);
        #1;
        pw_in = '0; bf_in = 1'b0; ng_in = 1'b0; cm_in = 1'b0; rst_n = 1'b1;
        $display("t=%0t pw=%b bf=%b ng=%b cm=%b rst=%b -> win=%b id=%0d drw=%b go=%b mo=%b sc=%h dc=%0d",
                 $time, pw, bf, ng, cm, rst, o_winner, o_winner_id, o_draw, o_game_over,
                 o_match_over, o_scores, o_draw_count);
    endtask

    task automatic test_reset();
        cycle('0, 0, 0, 0, 0);
        cycle('0, 0, 0, 0, 0);
        n_cmp++; if (dut_vec !== '0) begin n_fail++; $display("FAIL reset_hold: got %h want 0", dut_vec); end
        cycle('0, 0, 0, 0, 1);
        n_cmp++; if (dut_vec !== '0) begin n_fail++; $display("FAIL reset_release: got %h want 0", dut_vec); end
    endtask

    task automatic test_win_latch();
        cycle(2'b10, 0, 0, 0, 1);
        n_cmp++; if ({o_winner, o_winner_id, o_draw, o_game_over, o_match_over, o_scores} !== {2'b10, 1'b1, 1'b0, 1'b1, 1'b0, 8'h10})
            begin n_fail++; $display("FAIL win_p1: got w=%b id=%0d go=%b sc=%h want w=10 id=1 go=1 sc=10", o_winner, o_winner_id, o_game_over, o_scores); end
        cycle(2'b01, 0, 0, 0, 1);
        n_cmp++; if ({o_winner, o_winner_id, o_scores} !== {2'b10, 1'b1, 8'h10})
            begin n_fail++; $display("FAIL late_claim: got w=%b sc=%h want w=10 sc=10", o_winner, o_scores); end
        cycle('0, 0, 1, 0, 1);
        n_cmp++; if ({o_winner, o_game_over, o_scores} !== {2'b00, 1'b0, 8'h10})
            begin n_fail++; $display("FAIL new_game: got w=%b go=%b sc=%h want w=00 go=0 sc=10", o_winner, o_game_over, o_scores); end
        cycle('0, 0, 1, 0, 1);
        n_cmp++; if ({o_game_over, o_scores} !== {1'b0, 8'h10})
            begin n_fail++; $display("FAIL ng_in_play: got go=%b sc=%h want go=0 sc=10", o_game_over, o_scores); end
    endtask

    task automatic test_draw();
        cycle('0, 1, 0, 0, 1);
        n_cmp++; if ({o_draw, o_game_over, o_draw_count, o_winner} !== {1'b1, 1'b1, 4'd1, 2'b00})
            begin n_fail++; $display("FAIL draw: got drw=%b go=%b dc=%0d want drw=1 go=1 dc=1", o_draw, o_game_over, o_draw_count); end
        cycle('0, 0, 1, 0, 1);
        cycle(2'b01, 1, 0, 0, 1);
        n_cmp++; if ({o_winner, o_draw, o_draw_count, o_scores} !== {2'b01, 1'b0, 4'd1, 8'h11})
            begin n_fail++; $display("FAIL win_beats_full: got w=%b drw=%b dc=%0d sc=%h want w=01 drw=0 dc=1 sc=11", o_winner, o_draw, o_draw_count, o_scores); end
        cycle('0, 0, 1, 0, 1);
    endtask

    task automatic test_ng_with_win_then_reset();
        cycle(2'b10, 0, 0, 0, 1);
        cycle(2'b01, 0, 1, 0, 1);
        cycle('0, 0, 0, 0, 1);
        n_cmp++; if ({o_winner, o_game_over, o_scores} !== {2'b00, 1'b0, 8'h21})
            begin n_fail++; $display("FAIL ng_with_win: got w=%b go=%b sc=%h want w=00 go=0 sc=21", o_winner, o_game_over, o_scores); end
        cycle('0, 0, 1, 0, 0);
        n_cmp++; if (dut_vec !== '0) begin n_fail++; $display("FAIL reset_mid_round: got %h want 0", dut_vec); end
        cycle(2'b01, 0, 0, 0, 1);
        n_cmp++; if ({o_winner, o_game_over, o_scores} !== {2'b01, 1'b1, 8'h01})
            begin n_fail++; $display("FAIL after_reset_win: got w=%b go=%b sc=%h want w=01 go=1 sc=01", o_winner, o_game_over, o_scores); end
    endtask

    task automatic test_match();
        cycle('0, 0, 0, 1, 1);
        n_cmp++; if (dut_vec !== '0) begin n_fail++; $display("FAIL clear_match: got %h want 0", dut_vec); end
        for (int r = 0; r < TGT; r++) begin
            if (r > 0) cycle('0, 0, 1, 0, 1);
            cycle(2'b01, 0, 0, 0, 1);
        end
        n_cmp++; if ({o_winner, o_game_over, o_match_over, o_scores} !== {2'b01, 1'b1, 1'b1, 8'h03})
            begin n_fail++; $display("FAIL match_over: got w=%b go=%b mo=%b sc=%h want w=01 go=1 mo=1 sc=03", o_winner, o_game_over, o_match_over, o_scores); end
        cycle('0, 0, 1, 0, 1);
        cycle(2'b10, 1, 0, 0, 1);
        n_cmp++; if ({o_winner, o_match_over, o_draw, o_scores, o_draw_count} !== {2'b01, 1'b1, 1'b0, 8'h03, 4'd0})
            begin n_fail++; $display("FAIL match_hold: got w=%b mo=%b sc=%h dc=%0d want w=01 mo=1 sc=03 dc=0", o_winner, o_match_over, o_scores, o_draw_count); end
        cycle('0, 0, 0, 1, 1);
        n_cmp++; if (dut_vec !== '0) begin n_fail++; $display("FAIL match_clear: got %h want 0", dut_vec); end
    endtask

    task automatic test_simultaneous();
        cycle(2'b11, 0, 0, 0, 1);
`ifdef GAME_RESULT_TIE_DRAW_EN
        n_cmp++; if ({o_draw, o_draw_count, o_scores, o_winner} !== {1'b1, 4'd1, 8'h00, 2'b00})
            begin n_fail++; $display("FAIL tie_draw: got drw=%b dc=%0d sc=%h w=%b want drw=1 dc=1 sc=00 w=00", o_draw, o_draw_count, o_scores, o_winner); end
`else
        n_cmp++; if ({o_winner, o_winner_id, o_draw, o_scores} !== {2'b01, 1'b0, 1'b0, 8'h01})
            begin n_fail++; $display("FAIL tie_lowest: got w=%b id=%0d drw=%b sc=%h want w=01 id=0 drw=0 sc=01", o_winner, o_winner_id, o_draw, o_scores); end
`endif
        cycle('0, 0, 0, 1, 1);
    endtask

    task automatic test_draw_saturate();
        for (int r = 0; r < SMAX + 2; r++) begin
            cycle('0, 1, 0, 0, 1);
            cycle('0, 0, 1, 0, 1);
        end
        n_cmp++; if ({o_draw, o_draw_count} !== {1'b0, 4'hF})
            begin n_fail++; $display("FAIL draw_saturate: got drw=%b dc=%0d want drw=0 dc=15", o_draw, o_draw_count); end
        cycle('0, 1, 0, 0, 1);
        n_cmp++; if ({o_draw, o_draw_count} !== {1'b1, 4'hF})
            begin n_fail++; $display("FAIL draw_sat_hold: got drw=%b dc=%0d want drw=1 dc=15", o_draw, o_draw_count); end
        cycle('0, 0, 0, 1, 1);
    endtask

    task automatic test_random();
        logic [N-1:0] pw;
        logic bf, ng, cm, rst;
        for (int t = 0; t < 600; t++) begin
            pw  = ($urandom_range(0, 3) == 0) ? N'($urandom) : '0;
            bf  = ($urandom_range(0, 7) == 0);
            ng  = ($urandom_range(0, 4) == 0);
            cm  = ($urandom_range(0, 59) == 0);
            rst = !($urandom_range(0, 99) == 0);
            cycle(pw, bf, ng, cm, rst);
            n_cmp++;
            if (dut_vec !== model_vec()) begin
                n_fail++;
                $display("FAIL random[%0d]: got %h want %h", t, dut_vec, model_vec());
            end
        end
    endtask

    initial begin
        model_clear();
        test_reset();
        test_win_latch();
        test_draw();
        test_ng_with_win_then_reset();
        test_match();
        test_simultaneous();
        test_draw_saturate();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
